seg7_scan_ctrl: RTL and testbench

Parametrised time-multiplexed seven-segment display controller for the board's common-anode digit array (active-low anodes and segments). It scans NUM_DIGITS hex digits from a packed input word using an internal refresh prescaler. It inserts a one-cycle all-off gap between digits to suppress ghosting. It also adds per-digit enables, decimal points, leading-zero blanking and frame-coherent snapshotting of the displayed value. It sits at the top level between the CPU debug/data bus and the board display pins.

---
 rtl/seg7_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with frame snapshot,
// per-digit enables, decimal points and leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 100000,
  parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0]    P_LAST = PW'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic                    sh_lz;
  logic                    load_pending;

  logic                  tick;
  logic                  wrap;
  logic                  snap;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  assign tick = en && (presc == P_LAST);
  assign wrap = tick && (idx == I_LAST);
  assign snap = wrap || (en && load_pending);

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Walk down from the top digit; a digit is blanked while
  // every nibble from the top down to it is still zero.
  always_comb begin
    logic nz;
    nz    = 1'b0;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz       = nz | (|sh_data[4*i +: 4]);
      blank[i] = sh_lz && !nz && (i != 0);
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (en && !tick) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if ((idx == IDX_W'(i)) && sh_en[i] && !blank[i]) begin
          an_d[i] = 1'b0;
          seg_d   = dec(sh_data[4*i +: 4]);
          dp_d    = ~sh_dp[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc        <= '0;
      idx          <= '0;
      sh_data      <= '0;
      sh_dp        <= '0;
      sh_en        <= '0;
      sh_lz        <= 1'b0;
      load_pending <= 1'b1;
      frame_done   <= 1'b0;
      an           <= '1;
      seg          <= 7'h7F;
      dp           <= 1'b1;
    end else begin
      if (tick) begin
        presc <= '0;
        idx   <= (idx == I_LAST) ? '0 : idx + 1'b1;
      end else if (en) begin
        presc <= presc + 1'b1;
      end
      if (snap) begin
        sh_data      <= data;
        sh_dp        <= dp_in;
        sh_en        <= digit_en;
        sh_lz        <= lz_blank;
        load_pending <= 1'b0;
      end
      frame_done <= wrap;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (4 digits, 4-cycle slots) with
// a frame-position reference model checked every cycle.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  bit chk   = 1'b0;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data),
    .dp_in(dp_in), .digit_en(digit_en), .lz_blank(lz_blank),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  // Scan position 0..15 in the frame: digit = pos/4, gap when pos%4==3.
  int          pos;
  bit          pend;
  logic [15:0] s_data;
  logic [3:0]  s_dp, s_en;
  logic        s_lz;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp, m_fd;

  function automatic logic [11:0] model_out(
    input int p, input logic e, input logic [15:0] sd,
    input logic [3:0] sdp, input logic [3:0] sen, input logic slz);
    logic [11:0] r;
    int          dg;
    logic [15:0] hi;
    r = {4'hF, 7'h7F, 1'b1};
    if (e && (p % 4 != 3)) begin
      dg = p / 4;
      hi = sd >> (4 * dg);
      if (sen[dg] && !(slz && dg > 0 && hi == 16'h0))
        r = {~(4'b0001 << dg), hex7(hi[3:0]), ~sdp[dg]};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      pos    <= 0;
      pend   <= 1'b1;
      s_data <= '0;
      s_dp   <= '0;
      s_en   <= '0;
      s_lz   <= 1'b0;
      m_an   <= 4'hF;
      m_seg  <= 7'h7F;
      m_dp   <= 1'b1;
      m_fd   <= 1'b0;
    end else begin
      {m_an, m_seg, m_dp} <= model_out(pos, en, s_data, s_dp, s_en, s_lz);
      m_fd <= en && (pos == 15);
      if ((en && pos == 15) || (en && pend)) begin
        s_data <= data;
        s_dp   <= dp_in;
        s_en   <= digit_en;
        s_lz   <= lz_blank;
        pend   <= 1'b0;
      end
      if (en) pos <= (pos + 1) % 16;
    end
  end

  task automatic step();
    @(negedge clk);
    if (chk) begin
      tests++;
      if ({an, seg, dp, frame_done} !== {m_an, m_seg, m_dp, m_fd}) begin
        fails++;
        $display("FAIL model t=%0t got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                 $time, an, seg, dp, frame_done, m_an, m_seg, m_dp, m_fd);
      end
    end
  endtask

  task automatic chk_lit(input string nm, input logic [3:0] ea,
                         input logic [6:0] es, input logic ed,
                         input logic ef);
    tests++;
    if ({an, seg, dp, frame_done} !== {ea, es, ed, ef}) begin
      fails++;
      $display("FAIL %s t=%0t got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
               nm, $time, an, seg, dp, frame_done, ea, es, ed, ef);
    end
  endtask

  task automatic wait_fd(input string nm);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    tests++;
    if (frame_done !== 1'b1) begin
      fails++;
      $display("FAIL %s frame_done timeout got %b want 1", nm, frame_done);
    end
  endtask

  task automatic check_frame(input string nm, input logic [15:0] ans,
                             input logic [27:0] segs, input logic [3:0] dps,
                             input int chg_p, input logic [15:0] chg);
    int s;
    for (int p = 0; p < 16; p++) begin
      step();
      s = p / 4;
      if (p % 4 == 3)
        chk_lit(nm, 4'hF, 7'h7F, 1'b1, (p == 15));
      else
        chk_lit(nm, ans[4*s +: 4], segs[7*s +: 7], dps[s], 1'b0);
      if (p == chg_p) data = chg;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    data     = 16'h12AF;
    dp_in    = 4'h0;
    digit_en = 4'hF;
    lz_blank = 1'b0;
    repeat (3) step();
    chk = 1'b1;
    chk_lit("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    rst_n = 1'b1;
    step();
    step();
    chk_lit("first_lit", 4'hE, 7'h0E, 1'b1, 1'b0);

    wait_fd("scan");
    check_frame("scan", 16'h7BDE, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, -1, 16'h0);
    check_frame("scan2", 16'h7BDE, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, -1, 16'h0);

    data     = 16'h0030;
    lz_blank = 1'b1;
    wait_fd("lz");
    check_frame("lz", 16'hFFDE, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'hF, -1, 16'h0);
    data = 16'h0000;
    wait_fd("lz0");
    check_frame("lz0", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, -1, 16'h0);

    data     = 16'h1111;
    lz_blank = 1'b0;
    wait_fd("snap");
    check_frame("snap_old", 16'h7BDE, {4{7'h79}}, 4'hF, 9, 16'h2222);
    check_frame("snap_new", 16'h7BDE, {4{7'h24}}, 4'hF, -1, 16'h0);

    data = 16'h12AF;
    wait_fd("enable");
    for (int p = 0; p < 6; p++) step();
    chk_lit("en_before", 4'hD, 7'h08, 1'b1, 1'b0);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_lit("en_off", 4'hF, 7'h7F, 1'b1, 1'b0);
    end
    en = 1'b1;
    step();
    chk_lit("en_resume", 4'hD, 7'h08, 1'b1, 1'b0);
    step();
    chk_lit("en_gap", 4'hF, 7'h7F, 1'b1, 1'b0);
    step();
    chk_lit("en_next", 4'hB, 7'h24, 1'b1, 1'b0);

    digit_en = 4'b0101;
    dp_in    = 4'b0011;
    wait_fd("mask");
    check_frame("mask", 16'hFBFE, {7'h7F, 7'h24, 7'h7F, 7'h0E}, 4'b1110, -1, 16'h0);

    digit_en = 4'hF;
    dp_in    = 4'h0;
    repeat (6) step();
    rst_n = 1'b0;
    repeat (3) step();
    chk_lit("mid_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    rst_n = 1'b1;
    step();
    chk_lit("rst_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
    step();
    chk_lit("rst_lit", 4'hE, 7'h0E, 1'b1, 1'b0);
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
